// File: rtl/propplug_pkg.sv
// Shared types and constants for the Propeller boot-UART arbiter.
package propplug_pkg;

  typedef enum logic [2:0] {
    ST_FTDI,
    ST_DRAIN_EXT,
    ST_RST_EXT,
    ST_EXT,
    ST_DRAIN_FTDI,
    ST_RST_FTDI
  } propplug_state_t;

  localparam logic OWNER_FTDI = 1'b0;
  localparam logic OWNER_EXT  = 1'b1;

endpackage

// File: rtl/propplug_arbiter_sync_debounce.sv
// Two-flop synchroniser plus counter debouncer for the ownership select switch.
module sync_debounce #(
  parameter int CYCLES = 1600000
) (
  input  logic clk,
  input  logic res,
  input  logic din,
  output logic sel_db
);

  localparam int CW = $clog2(CYCLES + 1);

  logic          meta;
  logic          sel_sync;
  logic [CW-1:0] count;

  // The count only advances while the synchronised input disagrees with the accepted value.
  always_ff @(posedge clk) begin
    if (res) begin
      meta     <= 1'b0;
      sel_sync <= 1'b0;
      count    <= '0;
      sel_db   <= 1'b0;
    end else begin
      meta     <= din;
      sel_sync <= meta;
      if (sel_sync == sel_db) begin
        count <= '0;
      end else if (count == CW'(CYCLES - 1)) begin
        sel_db <= sel_sync;
        count  <= '0;
      end else if (count != CW'(CYCLES)) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/propplug_arbiter.sv
// Sequenced handover of the Propeller boot UART (P31/P30) between the FTDI bridge and the header.
// Define PROPPLUG_RESET_EN to pulse prop_res_req during each handover; otherwise RST_x is a 1-cycle guard.
module propplug_arbiter
  import propplug_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES    = 1600000,
  parameter int IDLE_CYCLES        = 16000,
  parameter int RESET_PULSE_CYCLES = 160
) (
  input  logic clock_160,
  input  logic res,
  input  logic sel_ext_raw,
  input  logic ftdi_txd,
  input  logic prop_tx,
  output logic ftdi_rxd,
  output logic ftdi_rxd_oe,
  output logic prop_rx,
  output logic prop_rx_oe,
  output logic owner,
  output logic busy,
  output logic prop_res_req
);

  localparam int IW = $clog2(IDLE_CYCLES + 1);

  propplug_state_t state, next_state;
  logic            sel_db;
  logic [IW-1:0]   idle_cnt, idle_next;
  logic            idle_done, pulse_done;
  logic            draining, resetting;
  logic            owner_q, owner_next;
  logic            drive_q, drive_next;
  logic            busy_q, busy_next;

  sync_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_sel (
    .clk    (clock_160),
    .res    (res),
    .din    (sel_ext_raw),
    .sel_db (sel_db)
  );

  assign draining  = (state == ST_DRAIN_EXT) || (state == ST_DRAIN_FTDI);
  assign resetting = (state == ST_RST_EXT) || (state == ST_RST_FTDI);

  // Idle run length of both lines; the handover proceeds on the cycle the run completes.
  always_comb begin
    idle_next = '0;
    if (draining && ftdi_txd && prop_tx)
      idle_next = (idle_cnt == IW'(IDLE_CYCLES)) ? idle_cnt : idle_cnt + 1'b1;
  end

  assign idle_done = (idle_next == IW'(IDLE_CYCLES));

`ifdef PROPPLUG_RESET_EN
  localparam int PW = $clog2(RESET_PULSE_CYCLES + 1);

  logic [PW-1:0] pulse_cnt, pulse_next;
  logic          req_q;

  always_comb begin
    pulse_next = '0;
    if (resetting)
      pulse_next = (pulse_cnt == PW'(RESET_PULSE_CYCLES)) ? pulse_cnt : pulse_cnt + 1'b1;
  end

  assign pulse_done = (pulse_next == PW'(RESET_PULSE_CYCLES));

  always_ff @(posedge clock_160) begin
    if (res) begin
      pulse_cnt <= '0;
      req_q     <= 1'b0;
    end else begin
      pulse_cnt <= pulse_done ? '0 : pulse_next;
      req_q     <= (next_state == ST_RST_EXT) || (next_state == ST_RST_FTDI);
    end
  end

  assign prop_res_req = req_q;
`else
  logic pulse_len_unused;

  assign pulse_len_unused = (RESET_PULSE_CYCLES > 0);
  assign pulse_done       = 1'b1;
  assign prop_res_req     = 1'b0;
`endif

  always_comb begin
    next_state = state;
    case (state)
      ST_FTDI:       if (sel_db) next_state = ST_DRAIN_EXT;
      ST_DRAIN_EXT:  if (!sel_db) next_state = ST_FTDI;
                     else if (idle_done) next_state = ST_RST_EXT;
      ST_RST_EXT:    if (pulse_done) next_state = ST_EXT;
      ST_EXT:        if (!sel_db) next_state = ST_DRAIN_FTDI;
      ST_DRAIN_FTDI: if (sel_db) next_state = ST_EXT;
                     else if (idle_done) next_state = ST_RST_FTDI;
      ST_RST_FTDI:   if (pulse_done) next_state = ST_FTDI;
      default:       next_state = ST_FTDI;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    owner_next = OWNER_FTDI;
    drive_next = 1'b1;
    busy_next  = 1'b0;
    case (next_state)
      ST_DRAIN_EXT:  busy_next = 1'b1;
      ST_RST_EXT: begin
        owner_next = OWNER_EXT;
        drive_next = 1'b0;
        busy_next  = 1'b1;
      end
      ST_EXT: begin
        owner_next = OWNER_EXT;
        drive_next = 1'b0;
      end
      ST_DRAIN_FTDI: begin
        owner_next = OWNER_EXT;
        drive_next = 1'b0;
        busy_next  = 1'b1;
      end
      ST_RST_FTDI: begin
        drive_next = 1'b0;
        busy_next  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_160) begin
    if (res) begin
      state    <= ST_FTDI;
      idle_cnt <= '0;
      owner_q  <= OWNER_FTDI;
      drive_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state    <= next_state;
      idle_cnt <= (draining && next_state == state) ? idle_next : '0;
      owner_q  <= owner_next;
      drive_q  <= drive_next;
      busy_q   <= busy_next;
    end
  end

  assign owner       = owner_q;
  assign busy        = busy_q;
  assign ftdi_rxd_oe = drive_q;
  assign prop_rx_oe  = drive_q;
  assign ftdi_rxd    = drive_q ? prop_tx : 1'b1;
  assign prop_rx     = drive_q ? ftdi_txd : 1'b1;

endmodule

// File: tb/tb_propplug_arbiter.sv
// Directed testbench for propplug_arbiter with a cycle-level ownership model and literal timing pins.
// Honours PROPPLUG_RESET_EN the same way the design does.
module tb_propplug_arbiter;

  localparam int DEB   = 8;
  localparam int IDLE  = 4;
  localparam int PULSE = 3;
`ifdef PROPPLUG_RESET_EN
  localparam int   PULSE_LEN = PULSE;
  localparam logic RESET_EN  = 1'b1;
`else
  localparam int   PULSE_LEN = 1;
  localparam logic RESET_EN  = 1'b0;
`endif

  localparam int PH_OWNED = 0;
  localparam int PH_DRAIN = 1;
  localparam int PH_RESET = 2;

  logic clock_160   = 1'b0;
  logic res         = 1'b1;
  logic sel_ext_raw = 1'b0;
  logic ftdi_txd    = 1'b1;
  logic prop_tx     = 1'b1;
  logic ftdi_rxd, ftdi_rxd_oe, prop_rx, prop_rx_oe, owner, busy, prop_res_req;

  int checks   = 0;
  int failures = 0;

  propplug_arbiter #(
    .DEBOUNCE_CYCLES    (DEB),
    .IDLE_CYCLES        (IDLE),
    .RESET_PULSE_CYCLES (PULSE)
  ) dut (
    .clock_160    (clock_160),
    .res          (res),
    .sel_ext_raw  (sel_ext_raw),
    .ftdi_txd     (ftdi_txd),
    .prop_tx      (prop_tx),
    .ftdi_rxd     (ftdi_rxd),
    .ftdi_rxd_oe  (ftdi_rxd_oe),
    .prop_rx      (prop_rx),
    .prop_rx_oe   (prop_rx_oe),
    .owner        (owner),
    .busy         (busy),
    .prop_res_req (prop_res_req)
  );

  always #5 clock_160 = ~clock_160;

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkCount(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic raw, input logic ft, input logic pt);
    res         = r;
    sel_ext_raw = raw;
    ftdi_txd    = ft;
    prop_tx     = pt;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock_160);
    #1;
  endtask

  // Ownership model: select seen two edges late, accepted after DEB disagreeing samples,
  // then drain on IDLE high cycles, then PULSE_LEN cycles of reset with the new owner.
  logic m_valid = 1'b0;
  logic m_s1, m_sync, m_db, m_owner;
  int   m_run, m_phase, m_idle, m_held;

  always @(posedge clock_160) begin
    if (res) begin
      m_valid = 1'b1;
      m_s1    = 1'b0;
      m_sync  = 1'b0;
      m_db    = 1'b0;
      m_owner = 1'b0;
      m_run   = 0;
      m_phase = PH_OWNED;
      m_idle  = 0;
      m_held  = 0;
    end else begin
      if (m_phase == PH_OWNED) begin
        if (m_db != m_owner) begin
          m_phase = PH_DRAIN;
          m_idle  = 0;
        end
      end else if (m_phase == PH_DRAIN) begin
        if (m_db == m_owner) begin
          m_phase = PH_OWNED;
        end else if (ftdi_txd && prop_tx) begin
          m_idle++;
          if (m_idle == IDLE) begin
            m_phase = PH_RESET;
            m_owner = ~m_owner;
            m_held  = 0;
          end
        end else begin
          m_idle = 0;
        end
      end else begin
        m_held++;
        if (m_held == PULSE_LEN) m_phase = PH_OWNED;
      end
      if (m_sync != m_db) begin
        m_run++;
        if (m_run == DEB) begin
          m_db  = m_sync;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_sync = m_s1;
      m_s1   = sel_ext_raw;
    end
  end

  logic watch_guard = 1'b0;
  logic watch_quiet = 1'b0;
  int   guard_cycles = 0;
  int   busy_seen = 0;
  int   req_seen = 0;
  int   oe_low_seen = 0;

  always @(negedge clock_160) begin
    logic exp_oe;
    if (m_valid) begin
      exp_oe = (m_phase != PH_RESET) && (m_owner == 1'b0);
      checkOutput("model_owner", owner, m_owner);
      checkOutput("model_busy", busy, m_phase != PH_OWNED);
      checkOutput("model_ftdi_rxd_oe", ftdi_rxd_oe, exp_oe);
      checkOutput("model_prop_rx_oe", prop_rx_oe, exp_oe);
      checkOutput("model_prop_res_req", prop_res_req, (m_phase == PH_RESET) && RESET_EN);
      checkOutput("model_ftdi_rxd", ftdi_rxd, exp_oe ? prop_tx : 1'b1);
      checkOutput("model_prop_rx", prop_rx, exp_oe ? ftdi_txd : 1'b1);
    end
    if (watch_guard && busy && !ftdi_rxd_oe && !prop_rx_oe) guard_cycles++;
    if (watch_quiet) begin
      if (busy) busy_seen++;
      if (prop_res_req) req_seen++;
      if (!ftdi_rxd_oe || !prop_rx_oe) oe_low_seen++;
    end
  end

  initial begin
    $display("[TB] start, PROPPLUG_RESET_EN=%0b", RESET_EN);

    // Reset and combinational pass-through.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    tick(2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clock_160);
    checkOutput("reset_owner", owner, 1'b0);
    checkOutput("reset_ftdi_rxd_oe", ftdi_rxd_oe, 1'b1);
    checkOutput("reset_prop_rx_oe", prop_rx_oe, 1'b1);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_req", prop_res_req, 1'b0);
    ftdi_txd = 1'b0;
    #1 checkOutput("pass_prop_rx_low", prop_rx, 1'b0);
    prop_tx = 1'b0;
    #1 checkOutput("pass_ftdi_rxd_low", ftdi_rxd, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);

    // Five-cycle glitch on the select must be rejected.
    tick(1);
    busy_seen = 0;
    watch_quiet = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    tick(5);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    tick(15);
    @(negedge clock_160);
    watch_quiet = 1'b0;
    checkCount("glitch_busy_cycles", busy_seen, 0);
    checkOutput("glitch_owner", owner, 1'b0);

    // Handover to external, select raised just after edge k.
    tick(1);
    guard_cycles = 0;
    watch_guard = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    tick(10);
    @(negedge clock_160);
    checkOutput("ho_k10_busy", busy, 1'b0);
    tick(1);
    @(negedge clock_160);
    checkOutput("ho_k11_busy", busy, 1'b1);
    checkOutput("ho_k11_oe", ftdi_rxd_oe, 1'b1);
    checkOutput("ho_k11_owner", owner, 1'b0);
    tick(4);
    @(negedge clock_160);
    checkOutput("ho_k15_oe", prop_rx_oe, 1'b0);
    checkOutput("ho_k15_owner", owner, 1'b1);
    checkOutput("ho_k15_req", prop_res_req, RESET_EN);
`ifdef PROPPLUG_RESET_EN
    tick(2);
    @(negedge clock_160);
    checkOutput("ho_k17_req", prop_res_req, 1'b1);
    tick(1);
    @(negedge clock_160);
    checkOutput("ho_k18_req", prop_res_req, 1'b0);
    checkOutput("ho_k18_busy", busy, 1'b0);
`else
    tick(1);
    @(negedge clock_160);
    checkOutput("ho_k16_busy", busy, 1'b0);
`endif
    checkOutput("ho_ext_owner", owner, 1'b1);
    checkOutput("ho_ext_oe", ftdi_rxd_oe, 1'b0);
    watch_guard = 1'b0;
    checkCount("ho_guard_cycles", guard_cycles, PULSE_LEN);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    tick(30);
    @(negedge clock_160);
    checkOutput("back_owner", owner, 1'b0);
    checkOutput("back_oe", ftdi_rxd_oe, 1'b1);

    // Drain stall: prop_tx low for 10 cycles right after DRAIN_EXT entry.
    tick(1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    tick(11);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    tick(10);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    tick(3);
    @(negedge clock_160);
    checkOutput("stall_u3_busy", busy, 1'b1);
    checkOutput("stall_u3_oe", ftdi_rxd_oe, 1'b1);
    tick(1);
    @(negedge clock_160);
    checkOutput("stall_u4_oe", ftdi_rxd_oe, 1'b0);
    checkOutput("stall_u4_owner", owner, 1'b1);
    tick(10);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    tick(30);
    @(negedge clock_160);
    checkOutput("stall_back_owner", owner, 1'b0);

    // Abort: select reverts while the drain is stalled.
    tick(1);
    req_seen = 0;
    oe_low_seen = 0;
    watch_quiet = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    tick(11);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    tick(10);
    @(negedge clock_160);
    checkOutput("abort_k21_busy", busy, 1'b1);
    tick(1);
    @(negedge clock_160);
    checkOutput("abort_k22_busy", busy, 1'b0);
    checkOutput("abort_k22_owner", owner, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    tick(20);
    @(negedge clock_160);
    watch_quiet = 1'b0;
    checkCount("abort_req_cycles", req_seen, 0);
    checkCount("abort_oe_low_cycles", oe_low_seen, 0);

    // Reset asserted in the middle of a handover.
    tick(1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    tick(12);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    @(negedge clock_160);
    checkOutput("midreset_busy", busy, 1'b0);
    checkOutput("midreset_owner", owner, 1'b0);
    checkOutput("midreset_oe", prop_rx_oe, 1'b1);
    tick(25);
    @(negedge clock_160);
    checkOutput("midreset_final_owner", owner, 1'b1);
    checkOutput("midreset_final_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
